// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider controller.
package div_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = '1;
    // Settle counter must hold SETTLE_CYCLES-1 for the full 1..15 range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FIXUP
    } div_state_e;
endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement: result = sel ? -value : value.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             sel,
    output logic [WIDTH-1:0] result
);
    assign result = sel ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/div_seq_ctrl.sv
// Start/settle/fixup controller around the combinational unsigned divider core.
// Optional macro DIV_ZERO_TRAP_EN adds div_zero_trap and suppresses hi/lo writes on divide-by-zero.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] core_q,
    output logic [WIDTH-1:0] core_m,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic             div_zero_trap
`endif
);
    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sgn_op, neg_dvd, neg_dvs, zero_op;
    logic [WIDTH-1:0] quo_cap, rem_cap;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix, rem_src;
    logic             accept, capture, finish;

    div_sign_fix #(.WIDTH(WIDTH)) u_dvd_mag (
        .value(dividend), .sel(is_signed & dividend[WIDTH-1]), .result(dvd_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_dvs_mag (
        .value(divisor), .sel(is_signed & divisor[WIDTH-1]), .result(dvs_mag));

    // On divide-by-zero the remainder path re-signs core_q, which restores the original dividend.
    assign rem_src = zero_op ? core_q : rem_cap;

    div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
        .value(quo_cap), .sel(sgn_op & (neg_dvd ^ neg_dvs)), .result(quo_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .value(rem_src), .sel(sgn_op & neg_dvd), .result(rem_fix));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = SETTLE;
            end
            SETTLE: begin
                capture = (cnt == '0);
                if (cnt == '0) state_nxt = FIXUP;
            end
            FIXUP: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            sgn_op   <= 1'b0;
            neg_dvd  <= 1'b0;
            neg_dvs  <= 1'b0;
            zero_op  <= 1'b0;
            quo_cap  <= '0;
            rem_cap  <= '0;
            core_q   <= '0;
            core_m   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_trap <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_trap <= 1'b0;
`endif
            if (accept) begin
                sgn_op   <= is_signed;
                neg_dvd  <= dividend[WIDTH-1];
                neg_dvs  <= divisor[WIDTH-1];
                zero_op  <= (divisor == '0);
                core_q   <= dvd_mag;
                core_m   <= dvs_mag;
                cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                div_zero <= 1'b0;
            end
            if (state == SETTLE && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (capture) begin
                quo_cap <= core_quotient;
                rem_cap <= core_remainder;
            end
            if (finish) begin
                done     <= 1'b1;
                div_zero <= zero_op;
                if (zero_op) begin
`ifdef DIV_ZERO_TRAP_EN
                    div_zero_trap <= 1'b1;
`else
                    lo <= DIV0_QUOTIENT;
                    hi <= rem_fix;
`endif
                end else begin
                    lo <= quo_fix;
                    hi <= rem_fix;
                end
            end
        end
    end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequential controller that sits directly upstream and downstream of the combinational unsigned non-restoring divider core. It accepts signed or unsigned 32-bit divide requests and registers operand magnitudes onto the core inputs. It holds those inputs for a fixed multicycle settle window, then captures and sign-corrects the core outputs. Results are written to the HI (remainder) and LO (quotient) registers, with a start/busy/done handshake to the CPU control unit.

Parameters:
WIDTH, 32, operand/result width; the core is fixed at 32.
SETTLE_CYCLES, 4, clocks core inputs are held stable before outputs are sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
core_q  output  WIDTH  registered dividend magnitude to core Q input
core_m  output  WIDTH  registered divisor magnitude to core M input
core_quotient  input  WIDTH  unsigned quotient from core
core_remainder  input  WIDTH  unsigned remainder from core
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; hi/lo updated in the same cycle
hi  output  WIDTH  remainder register
lo  output  WIDTH  quotient register
div_zero  output  1  sticky flag: last completed op had divisor 0; cleared by the next accepted start

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, core_q 0, core_m 0, div_zero 0. This applies in any state and abandons any op in progress; no done is produced.
- States:
  - IDLE: if start=1, latch is_signed, the operand signs and the zero-divisor flag. Register core_q=|dividend| and core_m=|divisor|; magnitudes are taken only when is_signed=1, otherwise raw values. Load counter=SETTLE_CYCLES-1, clear div_zero, go to SETTLE.
  - SETTLE: decrement counter each cycle. When counter=0, capture core_quotient/core_remainder into internal regs and go to FIXUP.
  - FIXUP: compute the final result, write hi/lo, pulse done, return to IDLE.
- Latency: fixed. Start is sampled at edge E0; done=1 and new hi/lo are visible in the cycle following edge E0+SETTLE_CYCLES+1. Latency is the same for every operand, including zero divisor.
- busy=1 whenever state is not IDLE; done never overlaps with a new acceptance. start while busy is ignored, with no queueing.
- Sign rules (is_signed=1): quotient is negated if the dividend and divisor signs differ, truncating toward zero. Remainder is negated if the dividend is negative. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag. This falls out of the rules above; no special case.
- Divisor zero: core outputs are ignored. lo=all ones, hi=original (unconverted) dividend, div_zero=1. Applies to both signed and unsigned ops.
- hi/lo are held between ops; only FIXUP writes them.

Optional Feature:
DIV_ZERO_TRAP_EN
- Defined: adds output port div_zero_trap (1 bit), a one-cycle pulse coincident with done on a zero-divisor op. hi/lo are NOT written on that op; they keep their prior values. div_zero still sets.
- Undefined: no trap port; zero-divisor results are written as specified above.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, SETTLE, FIXUP}
  - WIDTH_DEFAULT=32
  - DIV0_QUOTIENT=all ones
  - counter width constant
- Sub-module div_sign_fix: combinational conditional two's-complement (negate when sel=1). It is instantiated for operand magnitude and for result correction.

Test Plan:
1. Unsigned op, SETTLE_CYCLES=4, start with dividend=100, divisor=7, is_signed=0. Required: lo=14, hi=2, done exactly 6 cycles after the start edge, busy high 5 cycles.
2. Signed op, dividend=0xFFFFFFF9 (-7), divisor=2. Required: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Second signed op, 7 / -2: lo=0xFFFFFFFD, hi=1.
3. Signed overflow, 0x80000000 / 0xFFFFFFFF. Required: lo=0x80000000, hi=0. Unsigned 0xFFFFFFFF / 1: lo=0xFFFFFFFF, hi=0.
4. Zero divisor, dividend=0x1234, divisor=0. Required: lo=0xFFFFFFFF, hi=0x1234, div_zero=1, same latency. With DIV_ZERO_TRAP_EN: div_zero_trap pulses with done and hi/lo keep their previous values.
5. Start re-asserted every cycle while busy. Required: exactly one done per accepted op, and operands of ignored starts never appear on core_q/core_m.
6. rst_n low for one edge mid-SETTLE. Required: next cycle shows busy=0, hi=lo=0, core_q=core_m=0, no done. A subsequent start of 9/3 gives lo=3, hi=0.
